sdram_read: RTL and testbench

Read-side engine of the FPGA SDRAM controller, the counterpart to the write engine. It pulls a programmed block of rows from bank 0 and pushes the data into the read FIFO (rfifo).
It sits under the same top-level arbiter as the write engine and uses the same request/grant/end handshake and refresh-yield rules. It issues ACT, READ and PRECHARGE commands with 4-beat bursts, and captures returning data after the CAS latency.

---
 rtl/sdram_read.sv | 200 ++++++++++++++++++++
 tb/tb_sdram_read.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_read.sv
// SDRAM read engine: fetches ROW_NUM rows from bank 0 in BURST_LEN-beat bursts
// under the arbiter handshake and streams the low data byte into the read FIFO.
module sdram_read #(
    parameter int unsigned CAS_LAT   = 3,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned ROW_NUM   = 2,
    parameter int unsigned COL_NUM   = 512,
    parameter int unsigned T_RCD     = 4,
    parameter int unsigned T_RP      = 4
) (
    input  logic        sclk,
    input  logic        s_rst_n,
    input  logic        rd_trig,
    input  logic        rd_en,
    output logic        rd_req,
    output logic        flag_rd_end,
    input  logic        ref_req,
    output logic [3:0]  rd_cmd,
    output logic [11:0] rd_addr,
    output logic [1:0]  bank_addr,
    input  logic [15:0] sdram_dq_in,
    output logic        rfifo_wr_en,
    output logic [7:0]  rfifo_wr_data
);

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned COL_W  = $clog2(COL_NUM);
    localparam int unsigned CNT_W  = $clog2((T_RCD > T_RP) ? T_RCD : T_RP) + 1;
    localparam int unsigned BCNT_W = $clog2(BURST_LEN);
    localparam int unsigned PIPE_W = CAS_LAT + BURST_LEN - 1;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_READ = 4'b0101;
    localparam logic [3:0] CMD_PRE  = 4'b0010;

    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_REQ  = 5'b00010,
        S_ACT  = 5'b00100,
        S_RD   = 5'b01000,
        S_PRE  = 5'b10000
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BCNT_W-1:0]   burst_q, burst_d;
    logic [ADDR_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic                flag_rd_q, flag_rd_d;
    logic                flag_end_q, flag_end_d;
    logic [3:0]          rd_cmd_q, rd_cmd_d;
    logic [PIPE_W-1:0]   pipe_q;
    logic                wr_en_q, wr_en_d;
    logic [7:0]          wr_data_q;
    logic                last_col;
    logic                job_done;
    logic                dq_hi_unused;

    assign dq_hi_unused = ^sdram_dq_in[15:8];

    // Next state, counters, addresses; the command is derived from where the FSM lands
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        burst_d    = burst_q;
        row_d      = row_q;
        col_d      = col_q;
        flag_rd_d  = flag_rd_q;
        flag_end_d = 1'b0;
        rd_cmd_d   = CMD_NOP;
        last_col   = (col_q == COL_W'(COL_NUM - BURST_LEN));
        job_done   = (row_q == ADDR_W'(ROW_NUM));

        case (state_q)
            S_IDLE: begin
                if (rd_trig && !flag_rd_q) begin
                    state_d   = S_REQ;
                    flag_rd_d = 1'b1;
                end
            end
            S_REQ: begin
                if (rd_en) begin
                    state_d = S_ACT;
                    cnt_d   = '0;
                end
            end
            S_ACT: begin
                if (cnt_q == CNT_W'(T_RCD - 1)) begin
                    state_d = S_RD;
                    cnt_d   = '0;
                    burst_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RD: begin
                burst_d = burst_q + BCNT_W'(1);
                if (burst_q == BCNT_W'(BURST_LEN - 1)) begin
                    if (last_col) begin
                        col_d = '0;
                        row_d = row_q + ADDR_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(BURST_LEN);
                    end
                    // last burst of the job is also the last burst of a row
                    if (last_col || ref_req) begin
                        state_d = S_PRE;
                        cnt_d   = '0;
                    end
                end
            end
            S_PRE: begin
                if (cnt_q == CNT_W'(T_RP - 1)) begin
                    cnt_d = '0;
                    if (job_done) begin
                        state_d    = S_IDLE;
                        flag_rd_d  = 1'b0;
                        row_d      = '0;
                        col_d      = '0;
                        flag_end_d = 1'b1;
                    end else if (ref_req) begin
                        state_d    = S_REQ;
                        flag_end_d = 1'b1;
                    end else begin
                        state_d = S_ACT;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_ACT:   if (cnt_d == '0)   rd_cmd_d = CMD_ACT;
            S_RD:    if (burst_d == '0) rd_cmd_d = CMD_READ;
            S_PRE:   if (cnt_d == '0)   rd_cmd_d = CMD_PRE;
            default: ;
        endcase
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            burst_q    <= '0;
            row_q      <= '0;
            col_q      <= '0;
            flag_rd_q  <= 1'b0;
            flag_end_q <= 1'b0;
            rd_cmd_q   <= CMD_NOP;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            burst_q    <= burst_d;
            row_q      <= row_d;
            col_q      <= col_d;
            flag_rd_q  <= flag_rd_d;
            flag_end_q <= flag_end_d;
            rd_cmd_q   <= rd_cmd_d;
        end
    end

    // Return-data window: beats arrive CAS_LAT after READ and are written one cycle later
    assign wr_en_d = |pipe_q[CAS_LAT-1 +: BURST_LEN];

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            pipe_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
        end else begin
            pipe_q  <= {pipe_q[PIPE_W-2:0], (rd_cmd_q == CMD_READ)};
            wr_en_q <= wr_en_d;
            if (wr_en_d) begin
                wr_data_q <= sdram_dq_in[7:0];
            end
        end
    end

    // Address follows the registered state so it lines up with rd_cmd
    always_comb begin
        rd_addr = '0;
        case (state_q)
            S_ACT:   rd_addr = row_q;
            S_RD:    rd_addr = ADDR_W'(col_q);
            S_PRE:   rd_addr = 12'h400;
            default: rd_addr = '0;
        endcase
    end

    assign rd_req        = (state_q == S_REQ);
    assign flag_rd_end   = flag_end_q;
    assign rd_cmd        = rd_cmd_q;
    assign bank_addr     = 2'b00;
    assign rfifo_wr_en   = wr_en_q;
    assign rfifo_wr_data = wr_data_q;

endmodule

// File: tb/tb_sdram_read.sv
// Directed bench for sdram_read with a CAS-latency SDRAM data model and beat scoreboard.
module tb_sdram_read;

    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] ACT  = 4'b0011;
    localparam logic [3:0] RD   = 4'b0101;
    localparam logic [3:0] PRE  = 4'b0010;
    localparam logic [15:0] FILL = 16'h5A5A;

    logic        sclk;
    logic        s_rst_n;
    logic        rd_trig;
    logic        rd_en;
    logic        rd_req;
    logic        flag_rd_end;
    logic        ref_req;
    logic [3:0]  rd_cmd;
    logic [11:0] rd_addr;
    logic [1:0]  bank_addr;
    logic [15:0] sdram_dq_in;
    logic        rfifo_wr_en;
    logic [7:0]  rfifo_wr_data;

    int errors = 0;
    int checks = 0;

    sdram_read dut (
        .sclk          (sclk),
        .s_rst_n       (s_rst_n),
        .rd_trig       (rd_trig),
        .rd_en         (rd_en),
        .rd_req        (rd_req),
        .flag_rd_end   (flag_rd_end),
        .ref_req       (ref_req),
        .rd_cmd        (rd_cmd),
        .rd_addr       (rd_addr),
        .bank_addr     (bank_addr),
        .sdram_dq_in   (sdram_dq_in),
        .rfifo_wr_en   (rfifo_wr_en),
        .rfifo_wr_data (rfifo_wr_data)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    // SDRAM model: READ seen in cycle t drives beats in cycles t+3..t+6
    logic [15:0] dq_line [0:6];
    logic [11:0] act_row;
    assign sdram_dq_in = dq_line[0];

    always @(posedge sclk) begin
        for (int k = 0; k < 6; k++) dq_line[k] <= dq_line[k+1];
        dq_line[6] <= FILL;
        if (rd_cmd == ACT) act_row <= rd_addr;
        if (rd_cmd == RD) begin
            for (int b = 0; b < 4; b++)
                dq_line[2+b] <= {8'h00, (8'(rd_addr[7:0] + 8'(b)) ^ (act_row[0] ? 8'hA5 : 8'h00))};
        end
    end

    // Expected byte of beat n of a job: row n/512, column n%512
    function automatic logic [7:0] exp_beat(input int n);
        logic [7:0] m;
        m = (((n / 512) % 2) == 1) ? 8'hA5 : 8'h00;
        return 8'(n % 256) ^ m;
    endfunction

    logic        mon_clr;
    int          beats, data_bad, reads, acts, pres, pre_bad, flags;
    logic [11:0] last_act;

    always @(negedge sclk) begin
        if (mon_clr) begin
            beats <= 0; data_bad <= 0; reads <= 0; acts <= 0;
            pres <= 0; pre_bad <= 0; flags <= 0; last_act <= '0;
        end else begin
            if (rfifo_wr_en) begin
                if (rfifo_wr_data !== exp_beat(beats)) data_bad <= data_bad + 1;
                beats <= beats + 1;
            end
            if (rd_cmd == RD) reads <= reads + 1;
            if (rd_cmd == ACT) begin
                acts     <= acts + 1;
                last_act <= rd_addr;
            end
            if (rd_cmd == PRE) begin
                pres <= pres + 1;
                if (rd_addr !== 12'h400) pre_bad <= pre_bad + 1;
            end
            if (flag_rd_end) flags <= flags + 1;
        end
    end

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic wait_cmd(input logic [3:0] cmd, input logic [11:0] addr, input bit match_addr,
                            input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            step();
            if (rd_cmd === cmd && (!match_addr || rd_addr === addr)) ok = 1'b1;
        end
    endtask

    task automatic wait_flag(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            step();
            if (flag_rd_end === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        step();
        mon_clr = 1'b0;
    endtask

    task automatic start_job();
        rd_trig = 1'b1;
        step();
        rd_trig = 1'b0;
    endtask

    task automatic test_reset();
        s_rst_n = 1'b0; rd_trig = 1'b0; rd_en = 1'b0; ref_req = 1'b0; mon_clr = 1'b0;
        repeat (8) step();
        checks++; if (rd_cmd !== NOP) begin errors++; $display("FAIL reset_cmd: got %h want %h", rd_cmd, NOP); end
        checks++; if (rd_addr !== 12'h000) begin errors++; $display("FAIL reset_addr: got %h want 000", rd_addr); end
        checks++; if (rfifo_wr_en !== 1'b0 || rfifo_wr_data !== 8'h00) begin
            errors++; $display("FAIL reset_fifo: got en=%b data=%h want en=0 data=00", rfifo_wr_en, rfifo_wr_data); end
        checks++; if (flag_rd_end !== 1'b0 || rd_req !== 1'b0 || bank_addr !== 2'b00) begin
            errors++; $display("FAIL reset_ctl: got end=%b req=%b bank=%b want 0 0 00", flag_rd_end, rd_req, bank_addr); end
        s_rst_n = 1'b1;
        step();
    endtask

    task automatic test_first_read();
        bit ok;
        int n;
        clear_mon();
        rd_en = 1'b1;
        start_job();
        checks++; if (rd_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", rd_req); end
        wait_cmd(ACT, 12'h0, 1'b0, 10, ok);
        checks++; if (!ok || rd_addr !== 12'h000) begin
            errors++; $display("FAIL first_act: got found=%0d addr=%h want found=1 addr=000", ok, rd_addr); end
        n = 0;
        do begin step(); n++; end while (rd_cmd !== RD && n < 10);
        checks++; if (n !== 4 || rd_addr !== 12'h000) begin
            errors++; $display("FAIL act_to_read: got %0d cycles addr=%h want 4 cycles addr=000", n, rd_addr); end
        repeat (3) step();
        checks++; if (rfifo_wr_en !== 1'b0) begin errors++; $display("FAIL early_wr_en: got %b want 0", rfifo_wr_en); end
        for (int b = 0; b < 4; b++) begin
            step();
            checks++; if (rfifo_wr_en !== 1'b1 || rfifo_wr_data !== 8'(b)) begin
                errors++; $display("FAIL first_beat%0d: got en=%b data=%h want en=1 data=%h", b, rfifo_wr_en, rfifo_wr_data, 8'(b)); end
        end
    endtask

    task automatic test_full_job();
        bit ok;
        wait_flag(3000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL job_end_timeout: got no flag want flag"); end
        checks++; if (beats !== 1024 || reads !== 256) begin
            errors++; $display("FAIL job_counts: got beats=%0d reads=%0d want 1024 256", beats, reads); end
        checks++; if (acts !== 2 || last_act !== 12'h001 || pres !== 2 || pre_bad !== 0) begin
            errors++; $display("FAIL job_rows: got act=%0d last_row=%h pre=%0d pre_bad=%0d want 2 001 2 0", acts, last_act, pres, pre_bad); end
        checks++; if (data_bad !== 0) begin errors++; $display("FAIL job_data: got %0d bad beats want 0", data_bad); end
        repeat (10) step();
        checks++; if (flags !== 1 || rd_req !== 1'b0 || rd_cmd !== NOP || rfifo_wr_en !== 1'b0) begin
            errors++; $display("FAIL job_idle: got flags=%0d req=%b cmd=%h wr=%b want 1 0 7 0", flags, rd_req, rd_cmd, rfifo_wr_en); end
    endtask

    task automatic test_refresh_yield();
        bit ok;
        int extra_reads;
        clear_mon();
        rd_en = 1'b1;
        start_job();
        wait_cmd(RD, 12'd100, 1'b1, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ref_col100: got no READ col 100 want READ"); end
        ref_req = 1'b1;
        rd_en   = 1'b0;
        extra_reads = 0;
        repeat (3) begin step(); if (rd_cmd === RD) extra_reads++; end
        step();
        checks++; if (extra_reads !== 0 || rd_cmd !== PRE || rd_addr !== 12'h400) begin
            errors++; $display("FAIL ref_pre: got reads=%0d cmd=%h addr=%h want 0 2 400", extra_reads, rd_cmd, rd_addr); end
        wait_flag(20, ok);
        checks++; if (!ok || rd_req !== 1'b1) begin
            errors++; $display("FAIL ref_yield: got flag=%0d req=%b want 1 1", ok, rd_req); end
        checks++; if (beats !== 104 || data_bad !== 0) begin
            errors++; $display("FAIL ref_beats: got beats=%0d bad=%0d want 104 0", beats, data_bad); end
        ref_req = 1'b0;
    endtask

    task automatic test_req_hold();
        int bad;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (rd_req !== 1'b1 || rd_cmd !== NOP) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL req_hold: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_refresh_resume();
        bit ok;
        rd_en = 1'b1;
        wait_cmd(ACT, 12'h0, 1'b0, 5, ok);
        checks++; if (!ok || rd_addr !== 12'h000) begin
            errors++; $display("FAIL resume_act: got found=%0d row=%h want 1 000", ok, rd_addr); end
        wait_cmd(RD, 12'h0, 1'b0, 10, ok);
        checks++; if (!ok || rd_addr !== 12'd104) begin
            errors++; $display("FAIL resume_col: got found=%0d col=%0d want 1 104", ok, rd_addr); end
        wait_flag(3000, ok);
        repeat (10) step();
        checks++; if (!ok || beats !== 1024 || reads !== 256 || data_bad !== 0 || flags !== 2) begin
            errors++; $display("FAIL resume_job: got end=%0d beats=%0d reads=%0d bad=%0d flags=%0d want 1 1024 256 0 2",
                               ok, beats, reads, data_bad, flags); end
    endtask

    task automatic test_retrigger();
        bit ok;
        clear_mon();
        rd_en = 1'b1;
        start_job();
        repeat (200) step();
        start_job();
        repeat (300) step();
        start_job();
        wait_flag(3000, ok);
        repeat (20) step();
        checks++; if (!ok || beats !== 1024 || flags !== 1 || acts !== 2 || rd_req !== 1'b0) begin
            errors++; $display("FAIL retrigger: got end=%0d beats=%0d flags=%0d acts=%0d req=%b want 1 1024 1 2 0",
                               ok, beats, flags, acts, rd_req); end
    endtask

    task automatic test_reset_mid_job();
        bit ok;
        int bad;
        clear_mon();
        rd_en = 1'b1;
        start_job();
        wait_cmd(RD, 12'd40, 1'b1, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_setup: got no READ col 40 want READ"); end
        step(); step();
        s_rst_n = 1'b0;
        #1;
        checks++; if (rd_cmd !== NOP || rd_addr !== 12'h000 || rd_req !== 1'b0 || flag_rd_end !== 1'b0) begin
            errors++; $display("FAIL rst_async_ctl: got cmd=%h addr=%h req=%b end=%b want 7 000 0 0", rd_cmd, rd_addr, rd_req, flag_rd_end); end
        checks++; if (rfifo_wr_en !== 1'b0 || rfifo_wr_data !== 8'h00) begin
            errors++; $display("FAIL rst_async_fifo: got en=%b data=%h want 0 00", rfifo_wr_en, rfifo_wr_data); end
        bad = 0;
        repeat (4) begin step(); if (rfifo_wr_en !== 1'b0) bad++; end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rst_no_partial: got %0d write cycles want 0", bad); end
        s_rst_n = 1'b1;
        step();
        clear_mon();
        start_job();
        wait_cmd(ACT, 12'h0, 1'b0, 10, ok);
        checks++; if (!ok || rd_addr !== 12'h000) begin
            errors++; $display("FAIL rst_restart_row: got found=%0d row=%h want 1 000", ok, rd_addr); end
        wait_cmd(RD, 12'h0, 1'b0, 10, ok);
        checks++; if (!ok || rd_addr !== 12'h000) begin
            errors++; $display("FAIL rst_restart_col: got found=%0d col=%h want 1 000", ok, rd_addr); end
        wait_flag(3000, ok);
        repeat (10) step();
        checks++; if (!ok || beats !== 1024 || data_bad !== 0) begin
            errors++; $display("FAIL rst_restart_job: got end=%0d beats=%0d bad=%0d want 1 1024 0", ok, beats, data_bad); end
    endtask

    initial begin
        test_reset();
        test_first_read();
        test_full_job();
        test_refresh_yield();
        test_req_hold();
        test_refresh_resume();
        test_retrigger();
        test_reset_mid_job();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
